// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Registered, parametrised ALU with valid/ready input and output
//            ports. Optional iterative shift-add multiply under ALU_MUL_EN.
// Revision : 1.0
// ============================================================================
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             illegal_op
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    localparam logic [WIDTH-1:0] C_WIDTH = WIDTH'(WIDTH);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_shift_big;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_result;
    logic               w_carry;
    logic               w_ovf;
    logic               w_illegal;

    assign w_sum       = {1'b0, in1} + {1'b0, in2};
    assign w_diff      = {1'b0, in1} - {1'b0, in2};
    // The whole of in2 counts as the shift amount; anything >= WIDTH saturates.
    assign w_shift_big = (in2 >= C_WIDTH);
    assign w_shamt     = in2[SHW-1:0];

    always_comb begin
        w_result  = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        case (alu_control)
            OP_AND:  w_result = in1 & in2;
            OP_OR:   w_result = in1 | in2;
            OP_XOR:  w_result = in1 ^ in2;
            OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = (in1[WIDTH-1] == in2[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
                w_ovf    = (in1[WIDTH-1] != in2[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_SLL:  w_result = w_shift_big ? '0 : (in1 << w_shamt);
            OP_SRL:  w_result = w_shift_big ? '0 : (in1 >> w_shamt);
            OP_SRA:  w_result = w_shift_big ? {WIDTH{in1[WIDTH-1]}}
                                            : $unsigned($signed(in1) >>> w_shamt);
`ifdef ALU_MUL_EN
            OP_MUL:  w_result = '0;
`endif
            default: w_illegal = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign in_ready   = (r_state == S_IDLE) && (!out_valid || out_ready);
`else
    assign in_ready   = !out_valid || out_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            zero_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            illegal_op    <= 1'b0;
`ifdef ALU_MUL_EN
            r_state       <= S_IDLE;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_acc         <= '0;
            r_count       <= '0;
`endif
        end else begin
`ifdef ALU_MUL_EN
            if (r_state == S_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    alu_result    <= w_acc_next;
                    zero_flag     <= (w_acc_next == '0);
                    carry_flag    <= 1'b0;
                    overflow_flag <= 1'b0;
                    illegal_op    <= 1'b0;
                    out_valid     <= 1'b1;
                    r_state       <= S_IDLE;
                end
            end else
`endif
            begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (in_valid && in_ready) begin
`ifdef ALU_MUL_EN
                    // Output slot is free (or freed this edge), so out_valid stays low during MUL.
                    if (alu_control == OP_MUL) begin
                        r_mcand  <= in1;
                        r_mplier <= in2;
                        r_acc    <= '0;
                        r_count  <= CW'(WIDTH);
                        r_state  <= S_MUL;
                    end else
`endif
                    begin
                        alu_result    <= w_result;
                        zero_flag     <= (w_result == '0);
                        carry_flag    <= w_carry;
                        overflow_flag <= w_ovf;
                        illegal_op    <= w_illegal;
                        out_valid     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Randomised and directed bench for alu_seq (WIDTH=32) against a
//            behavioural model; honours ALU_MUL_EN like the design.
// Revision : 1.0
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic        il;
        logic        ov;
        logic        cy;
        logic        z;
        logic [31:0] r;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in1 = '0;
    logic [WIDTH-1:0]  in2 = '0;
    logic [3:0]        alu_control = 4'd0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH-1:0]  alu_result;
    logic              zero_flag;
    logic              carry_flag;
    logic              overflow_flag;
    logic              illegal_op;

    int total = 0;
    int bad   = 0;

    // Model of the output slot: held result, whether valid, MUL cycles remaining.
    res_t m_exp;
    bit   m_valid = 1'b0;
    int   m_pend  = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in1           (in1),
        .in2           (in2),
        .alu_control   (alu_control),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_result    (alu_result),
        .zero_flag     (zero_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        res_t        o;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] t;
        longint      sa;
        longint      sb;
        longint      st;
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        o  = '0;
        case (op)
            4'd0: o.r = a & b;
            4'd1: o.r = a | b;
            4'd7: o.r = a ^ b;
            4'd2: begin
                t = ua + ub; o.r = t[31:0]; o.cy = t[32];
                st = sa + sb; o.ov = (st > SMAX) || (st < SMIN);
            end
            4'd4: begin
                t = ua - ub; o.r = t[31:0]; o.cy = (a < b);
                st = sa - sb; o.ov = (st > SMAX) || (st < SMIN);
            end
            4'd8: o.r = (a < b) ? 32'd1 : 32'd0;
            4'd9: o.r = (sa < sb) ? 32'd1 : 32'd0;
            4'd3: o.r = (b >= 32) ? 32'd0 : (a << b[4:0]);
            4'd5: o.r = (b >= 32) ? 32'd0 : (a >> b[4:0]);
            4'd10: begin
                if (b >= 32) o.r = a[31] ? 32'hFFFF_FFFF : 32'd0;
                else begin
                    o.r = a >> b[4:0];
                    if (a[31]) o.r = o.r | ~(32'hFFFF_FFFF >> b[4:0]);
                end
            end
            4'd6: begin
                if (MUL_ON) begin t = ua * ub; o.r = t[31:0]; end
                else o.il = 1'b1;
            end
            default: o.il = 1'b1;
        endcase
        o.z = (o.r == 32'd0);
        return o;
    endfunction

    // One clock: check outputs against the model, drive inputs, advance the model.
    task automatic step(input bit iv, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit ordy);
        bit rdy_exp;
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("result",   alu_result,    m_exp.r);
            chk("zero",     zero_flag,     m_exp.z);
            chk("carry",    carry_flag,    m_exp.cy);
            chk("overflow", overflow_flag, m_exp.ov);
            chk("illegal",  illegal_op,    m_exp.il);
        end
        in_valid = iv; alu_control = op; in1 = a; in2 = b; out_ready = ordy;
        #1;
        rdy_exp = (m_pend == 0) && (!m_valid || ordy);
        chk("in_ready", in_ready, rdy_exp);
        if (m_valid && ordy) m_valid = 1'b0;
        if (m_pend != 0) begin
            m_pend--;
            if (m_pend == 0) m_valid = 1'b1;
        end
        if (iv && rdy_exp) begin
            m_exp = ref_alu(op, a, b);
            if (op == 4'd6 && MUL_ON) m_pend = WIDTH;
            else m_valid = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic lit(input string tag, input logic [31:0] r, input bit z, input bit c,
                       input bit o, input bit il);
        chk({tag, "_valid"}, out_valid,     1'b1);
        chk({tag, "_res"},   alu_result,    r);
        chk({tag, "_zero"},  zero_flag,     z);
        chk({tag, "_carry"}, carry_flag,    c);
        chk({tag, "_ovf"},   overflow_flag, o);
        chk({tag, "_ill"},   illegal_op,    il);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, out_valid,     1'b0);
        chk({tag, "_res"},   alu_result,    32'd0);
        chk({tag, "_zero"},  zero_flag,     1'b0);
        chk({tag, "_carry"}, carry_flag,    1'b0);
        chk({tag, "_ovf"},   overflow_flag, 1'b0);
        chk({tag, "_ill"},   illegal_op,    1'b0);
        chk({tag, "_rdy"},   in_ready,      1'b1);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        step(1, 4'd2, 32'hFFFF_FFFF, 32'd1, 1);
        lit("add_wrap", 32'd0, 1, 1, 0, 0);
        step(1, 4'd2, 32'h7FFF_FFFF, 32'd1, 1);
        lit("add_ovf", 32'h8000_0000, 0, 0, 1, 0);
        step(1, 4'd4, 32'd3, 32'd5, 1);
        lit("sub_borrow", 32'hFFFF_FFFE, 0, 1, 0, 0);
        step(1, 4'd8, 32'hFFFF_FFFF, 32'd1, 1);
        lit("sltu", 32'd0, 1, 0, 0, 0);
        step(1, 4'd9, 32'hFFFF_FFFF, 32'd1, 1);
        lit("slt", 32'd1, 0, 0, 0, 0);
        step(1, 4'd10, 32'h8000_0000, 32'd4, 1);
        lit("sra4", 32'hF800_0000, 0, 0, 0, 0);
        step(1, 4'd10, 32'h8000_0000, 32'd40, 1);
        lit("sra40", 32'hFFFF_FFFF, 0, 0, 0, 0);
        step(1, 4'd3, 32'd1, 32'd32, 1);
        lit("sll32", 32'd0, 1, 0, 0, 0);
        step(1, 4'd12, 32'h1234, 32'h5678, 1);
        lit("illegal", 32'd0, 1, 0, 0, 1);
        step(1, 4'd6, 32'h0001_0001, 32'h0001_0001, 1);
        if (MUL_ON) begin
            for (int i = 0; i < WIDTH; i++) step(1, 4'd0, 32'hFFFF, 32'hFFFF, 1);
            lit("mul", 32'h0002_0001, 0, 0, 0, 0);
        end else begin
            lit("mul_off", 32'd0, 1, 0, 0, 1);
        end

        // Output stall: in_valid held high, nothing accepted until out_ready rises.
        step(1, 4'd2, 32'd5, 32'd6, 1);
        for (int i = 0; i < 5; i++) step(1, 4'd4, 32'd100, 32'd1, 0);
        lit("stall_hold", 32'd11, 0, 0, 0, 0);
        step(1, 4'd4, 32'd100, 32'd1, 1);
        lit("stall_next", 32'd99, 0, 0, 0, 0);

        // Asynchronous reset with a held result, no clock edge needed.
        step(1, 4'd1, 32'hF0, 32'h0F, 0);
        step(0, 4'd0, 32'd0, 32'd0, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        m_valid = 1'b0; m_pend = 0;

        if (MUL_ON) begin
            step(1, 4'd6, 32'd3, 32'd5, 1);
            for (int i = 0; i < 5; i++) step(0, 4'd0, 32'd0, 32'd0, 1);
            rst_n = 1'b0;
            #1;
            check_reset_outputs("mul_rst");
            @(negedge clk);
            rst_n = 1'b1;
            m_valid = 1'b0; m_pend = 0;
            for (int i = 0; i < WIDTH + 8; i++) step(0, 4'd0, 32'd0, 32'd0, 1);
            step(1, 4'd12, 32'd7, 32'd9, 1);
            lit("post_rst_ill", 32'd0, 1, 0, 0, 1);
        end

        for (int i = 0; i < 800; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
            step($urandom_range(0, 9) < 7, op, a, b, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < WIDTH + 4; i++) step(0, 4'd0, 32'd0, 32'd0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
